// File: rtl/lb_refill_ctrl_if.sv
// Grant, line-buffer and drain-side signals of the MSHR refill controller.
// The controller uses the slave modport; the surrounding logic uses master.
interface lb_refill_ctrl_if #(
  parameter int unsigned NSLOTS = 4,
  parameter int unsigned BEATS  = 8,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned SW = $clog2(NSLOTS);
  localparam int unsigned BW = $clog2(BEATS);
  localparam int unsigned AW = SW + BW;

  logic              alloc_valid;
  logic [SW-1:0]     alloc_slot;
  logic              gnt_valid;
  logic              gnt_ready;
  logic [SW-1:0]     gnt_slot;
  logic [DATA_W-1:0] gnt_data;
  logic              lb_w_en;
  logic [AW-1:0]     lb_w_addr;
  logic [DATA_W-1:0] lb_w_data;
  logic              lb_r_en;
  logic [AW-1:0]     lb_r_addr;
  logic [DATA_W-1:0] lb_r_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [SW-1:0]     wb_slot;
  logic [BW-1:0]     wb_beat;
  logic              wb_last;
  logic [DATA_W-1:0] wb_data;
  logic [NSLOTS-1:0] slot_free;
  logic              err;

  modport slave (
    input  alloc_valid, alloc_slot, gnt_valid, gnt_slot, gnt_data, lb_r_data, wb_ready,
    output gnt_ready, lb_w_en, lb_w_addr, lb_w_data, lb_r_en, lb_r_addr,
           wb_valid, wb_slot, wb_beat, wb_last, wb_data, slot_free, err
  );

  modport master (
    output alloc_valid, alloc_slot, gnt_valid, gnt_slot, gnt_data, lb_r_data, wb_ready,
    input  gnt_ready, lb_w_en, lb_w_addr, lb_w_data, lb_r_en, lb_r_addr,
           wb_valid, wb_slot, wb_beat, wb_last, wb_data, slot_free, err
  );
endinterface

// File: rtl/lb_refill_ctrl.sv
// MSHR line-buffer refill controller: writes tagged grant beats into the buffer,
// queues completed lines in completion order and streams them to the data array.
module lb_refill_ctrl #(
  parameter int unsigned NSLOTS = 4,
  parameter int unsigned BEATS  = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  lb_refill_ctrl_if.slave  bus
);
  localparam int unsigned SW = $clog2(NSLOTS);
  localparam int unsigned BW = $clog2(BEATS);

  typedef enum logic [1:0] {S_FREE, S_FILLING, S_QUEUED, S_DRAINING} slot_st_e;
  typedef enum logic {D_IDLE, D_DRAIN} drain_st_e;

  slot_st_e      st_q  [NSLOTS];
  slot_st_e      st_d  [NSLOTS];
  logic [BW-1:0] cnt_q [NSLOTS];
  logic [BW-1:0] cnt_d [NSLOTS];
  logic [SW-1:0] fifo_q [NSLOTS];
  logic [SW-1:0] rd_ptr_q, wr_ptr_q;
  logic [SW:0]   fcnt_q;
  drain_st_e     dst_q, dst_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          err_q, err_d;
  logic          push, pop, w_en, draining;
  logic [SW-1:0] head;

  assign head     = fifo_q[rd_ptr_q];
  assign draining = (dst_q == D_DRAIN);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    dst_d  = dst_q;
    cur_d  = cur_q;
    beat_d = beat_q;
    push   = 1'b0;
    pop    = 1'b0;
    w_en   = 1'b0;

    if (bus.alloc_valid) begin
      if (st_q[bus.alloc_slot] == S_FREE) begin
        st_d[bus.alloc_slot]  = S_FILLING;
        cnt_d[bus.alloc_slot] = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (bus.gnt_valid) begin
      if (st_q[bus.gnt_slot] == S_FILLING) begin
        w_en = 1'b1;
        cnt_d[bus.gnt_slot] = cnt_q[bus.gnt_slot] + BW'(1);
        if (cnt_q[bus.gnt_slot] == BW'(BEATS - 1)) begin
          st_d[bus.gnt_slot] = S_QUEUED;
          push = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Each slot is in exactly one state, so alloc/grant/free/pop never target the same slot.
    case (dst_q)
      D_IDLE: begin
        if (fcnt_q != '0) begin
          pop          = 1'b1;
          cur_d        = head;
          beat_d       = '0;
          st_d[head]   = S_DRAINING;
          dst_d        = D_DRAIN;
        end
      end
      D_DRAIN: begin
        if (bus.wb_ready) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BEATS - 1)) begin
            st_d[cur_q] = S_FREE;
            if (fcnt_q != '0) begin
              pop        = 1'b1;
              cur_d      = head;
              beat_d     = '0;
              st_d[head] = S_DRAINING;
            end else begin
              dst_d = D_IDLE;
            end
          end
        end
      end
      default: dst_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        st_q[i]   <= S_FREE;
        cnt_q[i]  <= '0;
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fcnt_q   <= '0;
      dst_q    <= D_IDLE;
      cur_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dst_q  <= dst_d;
      cur_q  <= cur_d;
      beat_q <= beat_d;
      err_q  <= err_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.gnt_slot;
        wr_ptr_q         <= wr_ptr_q + SW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + SW'(1);
      fcnt_q <= fcnt_q + (SW+1)'(push) - (SW+1)'(pop);
    end
  end

  assign bus.gnt_ready = reset_n;
  assign bus.lb_w_en   = w_en;
  assign bus.lb_w_addr = w_en ? {bus.gnt_slot, cnt_q[bus.gnt_slot]} : '0;
  assign bus.lb_w_data = w_en ? bus.gnt_data : '0;
  assign bus.lb_r_en   = draining;
  assign bus.lb_r_addr = draining ? {cur_q, beat_q} : '0;
  assign bus.wb_valid  = draining;
  assign bus.wb_slot   = draining ? cur_q : '0;
  assign bus.wb_beat   = draining ? beat_q : '0;
  assign bus.wb_last   = draining && (beat_q == BW'(BEATS - 1));
  assign bus.wb_data   = draining ? bus.lb_r_data : '0;
  assign bus.err       = err_q;

  always_comb begin
    bus.slot_free = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) bus.slot_free[i] = (st_q[i] == S_FREE);
  end
endmodule

// File: tb/tb_lb_refill_ctrl.sv
// Directed bench for lb_refill_ctrl with a line-buffer model and an in-order drain scoreboard.
module tb_lb_refill_ctrl;
  logic clock = 1'b0;
  logic reset_n;

  lb_refill_ctrl_if #(.NSLOTS(4), .BEATS(8), .DATA_W(64)) bus ();

  lb_refill_ctrl #(.NSLOTS(4), .BEATS(8), .DATA_W(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  logic [63:0] tb_mem [32];
  always @(posedge clock) if (bus.lb_w_en) tb_mem[bus.lb_w_addr] <= bus.lb_w_data;
  assign bus.lb_r_data = tb_mem[bus.lb_r_addr];

  typedef struct packed {
    logic [1:0]  slot;
    logic [2:0]  beat;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          mcnt [4];
  logic [63:0] mdata [4][8];
  logic [3:0]  pat = 4'b1001;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] s);
    bus.alloc_valid = 1'b1;
    bus.alloc_slot  = s;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  // Drive one accepted grant beat; the model pushes the whole line once its last beat goes in.
  task automatic gnt_beat(input logic [1:0] s, input logic [63:0] d);
    bus.gnt_valid = 1'b1;
    bus.gnt_slot  = s;
    bus.gnt_data  = d;
    #1;
    chk("lb_w_en", 64'(bus.lb_w_en), 64'd1);
    chk("lb_w_addr", 64'(bus.lb_w_addr), 64'(s) * 8 + 64'(mcnt[s]));
    chk("lb_w_data", bus.lb_w_data, d);
    mdata[s][mcnt[s]] = d;
    mcnt[s]++;
    if (mcnt[s] == 8) begin
      for (int k = 0; k < 8; k++) sb.push_back('{slot: s, beat: 3'(k), data: mdata[s][k]});
      mcnt[s] = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain_wait(input bit bp, output int n);
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      bus.wb_ready = bp ? pat[n % 4] : 1'b1;
      tick();
      n++;
    end
    bus.wb_ready = 1'b1;
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 64'(bus.wb_valid), 64'd0);
      end else begin
        chk("wb_slot", 64'(bus.wb_slot), 64'(sb[0].slot));
        chk("wb_beat", 64'(bus.wb_beat), 64'(sb[0].beat));
        chk("wb_data", bus.wb_data, sb[0].data);
        chk("wb_last", 64'(bus.wb_last), 64'(sb[0].beat == 3'd7));
        if (bus.wb_ready) begin
          void'(sb.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    int n;
    int hs0;
    bus.alloc_valid = 1'b0;
    bus.alloc_slot  = '0;
    bus.gnt_valid   = 1'b0;
    bus.gnt_slot    = '0;
    bus.gnt_data    = '0;
    bus.wb_ready    = 1'b1;
    for (int s = 0; s < 4; s++) mcnt[s] = 0;
    reset_n = 1'b0;
    #2;
    chk("rst_slot_free", 64'(bus.slot_free), 64'hf);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_lb_w_en", 64'(bus.lb_w_en), 64'd0);
    chk("rst_lb_r_en", 64'(bus.lb_r_en), 64'd0);
    chk("rst_gnt_ready", 64'(bus.gnt_ready), 64'd0);
    chk("rst_lb_r_addr", 64'(bus.lb_r_addr), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("gnt_ready", 64'(bus.gnt_ready), 64'd1);

    // Full line into slot 2
    do_alloc(2'd2);
    chk("free_after_alloc", 64'(bus.slot_free), 64'b1011);
    for (int i = 0; i < 8; i++) gnt_beat(2'd2, 64'h100 + 64'(i));
    bus.gnt_valid = 1'b0;
    chk("valid_at_T+1", 64'(bus.wb_valid), 64'd0);
    chk("free_queued", 64'(bus.slot_free), 64'b1011);
    tick();
    chk("valid_at_T+2", 64'(bus.wb_valid), 64'd1);
    drain_wait(1'b0, n);
    chk("full_line_cycles", 64'(n), 64'd8);
    chk("free_after_drain", 64'(bus.slot_free), 64'hf);
    chk("idle_after_drain", 64'(bus.wb_valid), 64'd0);

    // Backpressure on slot 0
    do_alloc(2'd0);
    for (int i = 0; i < 8; i++) gnt_beat(2'd0, {32'hbeef0000, 32'($urandom)});
    bus.gnt_valid = 1'b0;
    hs0 = hs_cnt;
    drain_wait(1'b1, n);
    chk("bp_handshakes", 64'(hs_cnt - hs0), 64'd8);

    // Interleave: slot 3 completes one cycle before slot 1
    do_alloc(2'd1);
    do_alloc(2'd3);
    for (int i = 0; i < 8; i++) begin
      gnt_beat(2'd3, 64'h300 + 64'(i));
      gnt_beat(2'd1, 64'h1100 + 64'(i));
    end
    bus.gnt_valid = 1'b0;
    drain_wait(1'b0, n);
    chk("interleave_cycles", 64'(n), 64'd16);
    chk("free_after_interleave", 64'(bus.slot_free), 64'hf);

    // Alloc of a FILLING slot
    do_alloc(2'd2);
    chk("err_clean", 64'(bus.err), 64'd0);
    do_alloc(2'd2);
    chk("err_alloc", 64'(bus.err), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(bus.err), 64'd1);

    // Reset while slot 1 drains beat 4
    do_alloc(2'd1);
    for (int i = 0; i < 8; i++) gnt_beat(2'd1, 64'ha00 + 64'(i));
    bus.gnt_valid = 1'b0;
    n = 0;
    while (!(bus.wb_valid && bus.wb_beat == 3'd4) && n < 50) begin
      tick();
      n++;
    end
    chk("beat4_reached", 64'(bus.wb_beat), 64'd4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("mid_rst_slot_free", 64'(bus.slot_free), 64'hf);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    chk("mid_rst_wb_data", bus.wb_data, 64'd0);
    sb.delete();
    for (int s = 0; s < 4; s++) mcnt[s] = 0;
    tick();
    reset_n = 1'b1;
    tick();
    do_alloc(2'd1);
    for (int i = 0; i < 8; i++) gnt_beat(2'd1, 64'hb00 + 64'(i));
    bus.gnt_valid = 1'b0;
    drain_wait(1'b0, n);
    chk("post_rst_free", 64'(bus.slot_free), 64'hf);

    // Grant to a FREE slot is dropped
    bus.gnt_valid = 1'b1;
    bus.gnt_slot  = 2'd0;
    bus.gnt_data  = 64'hdead;
    #1;
    chk("drop_no_write", 64'(bus.lb_w_en), 64'd0);
    tick();
    bus.gnt_valid = 1'b0;
    chk("err_grant", 64'(bus.err), 64'd1);
    tick();
    chk("drop_no_drain", 64'(bus.wb_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lb_refill_ctrl.md
# lb_refill_ctrl

Refill-side controller for the MSHR line buffer (32 entries x 64 bits, one read and one write port, combinational read).
- Fill path: accepts refill grant beats, which are already tagged with a line-buffer slot, and writes them into the buffer's write port.
- Drain path: tracks per-slot beat counts and queues completed lines in completion order. It then streams each completed line out of the buffer's read port toward the data-array write path with a valid/ready handshake.
- Position: sits between the grant channel and the line buffer (upstream, write side) and between the line buffer and the data-array writer (downstream, read side).

## Interface
- NSLOTS, 4, number of line slots (power of 2).
- BEATS, 8, 64-bit beats per line (power of 2); NSLOTS*BEATS = 32 = buffer depth.
- DATA_W, 64, beat width.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  claim slot alloc_slot for a new refill.
- alloc_slot  in  2  slot being claimed.
- gnt_valid  in  1  grant beat present.
- gnt_ready  out  1  always 1 out of reset; 0 while reset_n low.
- gnt_slot  in  2  destination slot of beat.
- gnt_data  in  64  beat payload.
- lb_w_en / lb_w_addr / lb_w_data  out  1/5/64  to buffer write port.
- lb_r_en / lb_r_addr  out  1/5  to buffer read port.
- lb_r_data  in  64  combinational read data from buffer.
- wb_valid  out  1  drain beat valid.
- wb_ready  in  1  data-array writer accepts beat.
- wb_slot  out  2  slot being drained.
- wb_beat  out  3  beat index within line.
- wb_last  out  1  wb_beat == BEATS-1.
- wb_data  out  64  equals lb_r_data.
- slot_free  out  NSLOTS  bit i set when slot i is FREE.
- err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Per-slot state: FREE -> FILLING -> QUEUED -> DRAINING -> FREE. Each slot has a 3-bit beat counter.
- Alloc:
  - alloc_valid with slot FREE -> FILLING, counter 0.
  - alloc to a non-FREE slot -> ignored, err set.
- Grant beat, accepted on gnt_valid (gnt_ready is high):
  - Slot FILLING: lb_w_en=1, lb_w_addr = gnt_slot*BEATS + counter, lb_w_data = gnt_data; counter++.
  - Counter was BEATS-1: slot -> QUEUED and slot id pushed to the completion FIFO.
  - Slot not FILLING: beat dropped, lb_w_en=0, err set.
- Completion FIFO:
  - NSLOTS entries, in-order.
  - Cannot overflow, since each slot is present at most once.
- Drain FSM, IDLE / DRAIN:
  - IDLE: FIFO non-empty -> pop, load cur_slot, beat=0, slot state -> DRAINING, go to DRAIN.
  - DRAIN: lb_r_en=1, lb_r_addr = cur_slot*BEATS + beat, wb_valid=1, wb_data = lb_r_data.
  - On wb_ready: beat++.
  - On the wb_ready handshake with wb_last: slot -> FREE. If the FIFO is non-empty, pop the next slot in the same cycle and stay in DRAIN with beat=0; otherwise go to IDLE.
  - While wb_valid is high and wb_ready is low, all wb_* outputs stay stable.
- Simultaneous events:
  - A slot freed at the last drain beat shows FREE from the next cycle. An alloc of that slot in the same cycle is rejected (err).
  - A FIFO push and pop in the same cycle are both honoured. A push into an empty FIFO is not visible to the pop until the next cycle.
  - Alloc and grant to different slots in the same cycle are both honoured.
- No read/write conflict on the buffer: the draining slot is never FILLING.
- Buffer contents are not owned by this block; reset does not clear them.

## Timing
- Reset values:
  - All slots FREE; slot_free = 4'b1111.
  - FIFO empty; FSM IDLE.
  - err=0, wb_valid=0, lb_w_en=0, lb_r_en=0.
  - All address and data outputs 0.
- Fill write is combinational from the accepted beat; data lands in the buffer at that clock edge.
- Last grant beat accepted in cycle T:
  - FIFO holds the slot at T+1.
  - First wb_valid at T+2 when the FSM is IDLE.
- Drain throughput: one beat per cycle while wb_ready=1. Consecutive queued lines drain with no bubble.
- slot_free reflects registered state; it updates one cycle after alloc or final drain handshake.
- reset_n asserted mid-fill or mid-drain: all in-flight lines are abandoned and outputs return to reset values immediately (asynchronously).

## Test plan
- Full line:
  - Stimulus: alloc slot 2, then 8 back-to-back beats 0x100..0x107 at T..T+7.
  - Response: lb_w_addr 16..23; wb_valid from T+9; wb_beat 0..7 with data 0x100..0x107; wb_last only on beat 7; slot_free[2] low from after alloc until one cycle after the last handshake.
- Backpressure:
  - Stimulus: wb_ready toggles 1,0,0,1… during drain.
  - Response: wb_data/wb_beat/wb_slot stable while stalled; exactly 8 handshakes; no beats lost.
- Interleave:
  - Stimulus: slots 1 and 3 allocated, beats alternating; slot 3 completes first.
  - Response: slot 3 drains before slot 1, back-to-back with no idle cycle between them.
- Errors:
  - Stimulus: grant to a FREE slot 0; alloc of a FILLING slot.
  - Response: err=1 and sticky; no lb_w_en pulse for the dropped beat.
- Reset mid-drain:
  - Stimulus: reset_n low at drain beat 4.
  - Response: wb_valid=0 and slot_free=4'b1111 immediately; after release, a fresh alloc and fill drains normally from beat 0.
